// File: rtl/rtc_bus_ctrl_if.sv
// Command, status and external bus signals between the PicoBlaze port decode and the RTC sequencer.
// The slave modport is the sequencer's view; the master modport is the CPU/board side.
interface rtc_bus_ctrl_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       overrun;
    logic       cs_n;
    logic       a_d;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport slave (
        input  start, rw, addr, wdata, ad_in,
        output rdata, busy, done, overrun, cs_n, a_d, rd_n, wr_n, ad_out, ad_oe
    );

    modport master (
        output start, rw, addr, wdata, ad_in,
        input  rdata, busy, done, overrun, cs_n, a_d, rd_n, wr_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed-bus sequencer: one read/write per start, done 2*(T_SU+T_PW+T_HD)+T_GAP+1 cycles after start.
// No backpressure: start while busy is dropped and flagged in the sticky overrun bit.
module rtc_bus_ctrl #(
    parameter int unsigned T_SU  = 2,
    parameter int unsigned T_PW  = 6,
    parameter int unsigned T_HD  = 2,
    parameter int unsigned T_GAP = 4
) (
    input  logic          clk,
    input  logic          reset,
    rtc_bus_ctrl_if.slave bus
);
    localparam int unsigned T_M1  = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int unsigned T_M2  = (T_HD > T_GAP) ? T_HD : T_GAP;
    localparam int unsigned T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int unsigned CW    = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ovr_q, ovr_d;
    logic          last;

    // Counter is loaded with length-1 so a phase ends on the cycle it reads zero.
    function automatic logic [CW-1:0] phase_len(input state_t s);
        case (s)
            A_SU, D_SU: phase_len = CW'(T_SU - 1);
            A_PW, D_PW: phase_len = CW'(T_PW - 1);
            A_HD, D_HD: phase_len = CW'(T_HD - 1);
            GAP:        phase_len = CW'(T_GAP - 1);
            default:    phase_len = '0;
        endcase
    endfunction

    assign last = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: if (bus.start) begin
                state_d = A_SU;
                rw_d    = bus.rw;
                addr_d  = bus.addr;
                wdata_d = bus.wdata;
            end
            A_SU: if (last) state_d = A_PW;
            A_PW: if (last) state_d = A_HD;
            A_HD: if (last) state_d = GAP;
            GAP:  if (last) state_d = D_SU;
            D_SU: if (last) state_d = D_PW;
            D_PW: if (last) begin
                state_d = D_HD;
                if (rw_q) rdata_d = bus.ad_in;
            end
            D_HD: if (last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Acceptance in IDLE clears overrun; any start seen while busy sets it.
        if (bus.start) ovr_d = (state_q != IDLE);

        if (state_d != state_q)  cnt_d = phase_len(state_d);
        else if (last)           cnt_d = cnt_q;
        else                     cnt_d = cnt_q - CW'(1);
    end

    always_comb begin
        bus.cs_n    = 1'b1;
        bus.a_d     = 1'b0;
        bus.rd_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.ad_oe   = 1'b0;
        bus.ad_out  = 8'h00;
        bus.busy    = (state_q != IDLE);
        bus.done    = 1'b0;
        bus.rdata   = rdata_q;
        bus.overrun = ovr_q;

        case (state_q)
            A_SU, A_PW, A_HD: begin
                bus.cs_n   = 1'b0;
                bus.ad_oe  = 1'b1;
                bus.ad_out = addr_q;
                if (state_q == A_PW) bus.wr_n = 1'b0;
            end
            D_SU, D_PW, D_HD: begin
                bus.cs_n   = 1'b0;
                bus.a_d    = 1'b1;
                bus.ad_oe  = ~rw_q;
                bus.ad_out = rw_q ? 8'h00 : wdata_q;
                if (state_q == D_PW) begin
                    if (rw_q) bus.rd_n = 1'b0;
                    else      bus.wr_n = 1'b0;
                end
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Sequences one read or write transaction on the multiplexed address/data bus of the external RTC chip, on behalf of the PicoBlaze.
- Inputs come from the PicoBlaze output-port decode: command strobe, address, write data and direction.
- Read data and status are returned to the PicoBlaze input-port mux.
- Generates cs_n, a_d, rd_n and wr_n with parameterised setup, pulse-width, hold and gap timing, counted in clk cycles.

Parameters:
- T_SU, 2, setup cycles per phase with bus driven and strobes inactive (>=1)
- T_PW, 6, strobe low-time cycles per phase (>=1)
- T_HD, 2, hold cycles per phase after strobe release (>=1)
- T_GAP, 4, cycles with cs_n high between address and data phases (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle command strobe from PicoBlaze decode
- rw  in  1  1 = read, 0 = write; sampled with start
- addr  in  8  RTC register address; sampled with start
- wdata  in  8  write data; sampled with start
- rdata  out  8  last read result
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- overrun  out  1  sticky: start arrived while busy
- cs_n  out  1  RTC chip select, active low
- a_d  out  1  0 = address phase, 1 = data phase
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write/address-latch strobe, active low
- ad_out  out  8  bus drive value
- ad_oe  out  1  tristate enable for ad_out
- ad_in  in  8  bus sample value

Behaviour:
- One clock; reset is synchronous and active-high, ports clk and reset.
- Reset values: rdata=0, busy=0, done=0, overrun=0, cs_n=1, a_d=0, rd_n=1, wr_n=1, ad_out=0, ad_oe=0. State goes to IDLE.
- Reset mid-transaction: all outputs return to these values at the reset edge. No done pulse. rdata is cleared.
- States: IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE. A single down-counter is reloaded on every state entry. A phase exits when the counter hits its last cycle.
- IDLE: start=1 latches rw, addr and wdata. Next state is A_SU; busy=1 from the next cycle. overrun is cleared on acceptance.
- A_SU (T_SU cycles): cs_n=0, a_d=0, ad_oe=1, ad_out=addr.
- A_PW (T_PW cycles): as A_SU plus wr_n=0. The address latches on the wr_n rising edge.
- A_HD (T_HD cycles): wr_n=1; address still driven.
- GAP (T_GAP cycles): cs_n=1, ad_oe=0, a_d=0.
- D_SU (T_SU cycles): cs_n=0, a_d=1. Write: ad_oe=1, ad_out=wdata. Read: ad_oe=0.
- D_PW (T_PW cycles): write drives wr_n=0; read drives rd_n=0. For a read, rdata<=ad_in on the clock edge that ends the last D_PW cycle.
- D_HD (T_HD cycles): strobes high; cs_n=0; write data still driven.
- DONE (1 cycle): done=1, busy=1, cs_n=1, ad_oe=0, a_d=0. Then IDLE.
- Latency: from the start edge to the done cycle is 2*(T_SU+T_PW+T_HD)+T_GAP+1 cycles. Defaults give 25; done is high on cycle 25 and busy falls on cycle 26.
- start while busy=1, including the DONE cycle: ignored and overrun<=1. The latched command is unchanged.
- rd_n and wr_n are never low at the same time. ad_oe is never 1 while rd_n=0.
- rdata holds its value across write transactions.

Test Plan:
- Hold reset for 3 cycles with start=1 -> all outputs at reset values; busy stays 0 after reset falls, because start was sampled only under reset.
- Write with addr=0x02, wdata=0x45 and default parameters:
  - ad_out=0x02 during the address phase, with wr_n low for exactly 6 cycles.
  - cs_n high for 4 cycles in GAP.
  - ad_out=0x45 with a_d=1 and wr_n low for 6 cycles.
  - rd_n stays 1 throughout.
  - done on cycle 25; rdata is unchanged.
- Read with addr=0x04 and ad_in driven to 0x59 only during D_PW:
  - ad_oe=0 in D_SU, D_PW and D_HD.
  - rd_n low for 6 cycles.
  - rdata=0x59 on the cycle after the strobe ends, and it holds after done.
- Pulse start again at cycle 10 of a transaction, with rw=1 and addr=0x07 -> overrun=1; the bus still completes the original command. The next accepted start clears overrun.
- Assert reset during A_PW -> cs_n=1, wr_n=1, ad_oe=0 at that edge. No done pulse; busy=0.
- Set parameters T_SU=1, T_PW=1, T_HD=1, T_GAP=1 and issue back-to-back writes, each started the cycle after busy falls -> each transaction has done at cycle 8 and phase lengths of exactly 1 cycle.
